// File: rtl/moore_seq_detect_pkg.sv
// Shared state encoding and decode helper for the "101" Moore detector.
package moore_seq_detect_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  function automatic logic is_detect(input state_t s);
    return (s == S3);
  endfunction

endpackage

// File: rtl/moore_seq_detect.sv
// Moore detector for the serial pattern "101"; z is a flop, never a decode of x.
// Optional saturating match counter enabled by MOORE_SEQ_DETECT_CNT_EN.
module moore_seq_detect
  import moore_seq_detect_pkg::*;
#(
  parameter bit OVERLAP = 1'b1
`ifdef MOORE_SEQ_DETECT_CNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  output logic             z
`ifdef MOORE_SEQ_DETECT_CNT_EN
  , output logic [CNT_W-1:0] det_count
`endif
);

  state_t current_state;
  state_t next_state_s;
  logic   z_r;

  // State register; z is registered alongside it so it always equals (current_state == S3)
  always_ff @(posedge clk) begin
    if (rst) begin
      current_state <= S0;
      z_r           <= 1'b0;
    end else begin
      current_state <= next_state_s;
      z_r           <= is_detect(next_state_s);
    end
  end

  assign z = z_r;

  // Next-state logic
  always_comb begin
    next_state_s = S0;
    case (current_state)
      S0: begin
        if (x) next_state_s = S1;
        else   next_state_s = S0;
      end
      S1: begin
        if (x) next_state_s = S1;
        else   next_state_s = S2;
      end
      S2: begin
        if (x) next_state_s = S3;
        else   next_state_s = S0;
      end
      S3: begin
        // Overlap keeps the trailing "1" of the match as progress toward "10"
        if (x)            next_state_s = S1;
        else if (OVERLAP) next_state_s = S2;
        else              next_state_s = S0;
      end
      default: next_state_s = S0;
    endcase
  end

`ifdef MOORE_SEQ_DETECT_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // Saturating count of edges that enter S3
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (is_detect(next_state_s) && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign det_count = cnt_r;
`endif

endmodule

// File: tb/tb_moore_seq_detect.sv
// Self-checking bench: overlapping and non-overlapping detectors driven by one stream,
// compared against a bit-history reference model. Counter checks under MOORE_SEQ_DETECT_CNT_EN.
module tb_moore_seq_detect;

  logic clk;
  logic rst;
  logic x;
  logic z_ov;
  logic z_no;
`ifdef MOORE_SEQ_DETECT_CNT_EN
  logic [7:0] cnt_ov;
  logic [7:0] cnt_no;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: bits received since the last reset, and the first index each
  // detector may still use when looking for a "101" window.
  int bits[$];
  int base_ov    = 0;
  int base_no    = 0;
  int cnt_exp_ov = 0;
  int cnt_exp_no = 0;

  moore_seq_detect #(.OVERLAP(1'b1)) dut_ov (
    .clk (clk),
    .rst (rst),
    .x   (x),
    .z   (z_ov)
`ifdef MOORE_SEQ_DETECT_CNT_EN
    , .det_count (cnt_ov)
`endif
  );

  moore_seq_detect #(.OVERLAP(1'b0)) dut_no (
    .clk (clk),
    .rst (rst),
    .x   (x),
    .z   (z_no)
`ifdef MOORE_SEQ_DETECT_CNT_EN
    , .det_count (cnt_no)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Progress toward "101" measured as the longest matching suffix of usable history
  function automatic int exp_state(input int base);
    int n;
    int avail;
    n     = bits.size();
    avail = n - base;
    if (avail >= 3 && bits[n-3] == 1 && bits[n-2] == 0 && bits[n-1] == 1) return 3;
    if (avail >= 2 && bits[n-2] == 1 && bits[n-1] == 0) return 2;
    if (avail >= 1 && bits[n-1] == 1) return 1;
    return 0;
  endfunction

  task automatic step(input logic xi, input logic ri, input string tag);
    int so;
    int sn;
    @(negedge clk);
    x   = xi;
    rst = ri;
    @(posedge clk);
    #1;
    if (ri) begin
      bits.delete();
      base_ov    = 0;
      base_no    = 0;
      cnt_exp_ov = 0;
      cnt_exp_no = 0;
      so         = 0;
      sn         = 0;
    end else begin
      bits.push_back(int'(xi));
      so = exp_state(base_ov);
      sn = exp_state(base_no);
      if (so == 3 && cnt_exp_ov < 255) cnt_exp_ov++;
      if (sn == 3 && cnt_exp_no < 255) cnt_exp_no++;
      if (sn == 3) base_no = bits.size();
    end
    check($sformatf("%s_state_ov", tag), {30'b0, dut_ov.current_state}, so);
    check($sformatf("%s_z_ov", tag), {31'b0, z_ov}, (so == 3) ? 1 : 0);
    check($sformatf("%s_state_no", tag), {30'b0, dut_no.current_state}, sn);
    check($sformatf("%s_z_no", tag), {31'b0, z_no}, (sn == 3) ? 1 : 0);
`ifdef MOORE_SEQ_DETECT_CNT_EN
    check($sformatf("%s_cnt_ov", tag), {24'b0, cnt_ov}, cnt_exp_ov);
    check($sformatf("%s_cnt_no", tag), {24'b0, cnt_no}, cnt_exp_no);
`endif
  endtask

  initial begin
    rst = 1'b1;
    x   = 1'b1;

    // Reset held for two edges with x=1
    step(1'b1, 1'b1, "rst_a");
    step(1'b1, 1'b1, "rst_b");

    // Basic match, then a 0 from S3
    step(1'b1, 1'b0, "basic1");
    step(1'b0, 1'b0, "basic2");
    step(1'b1, 1'b0, "basic3");
    check("basic_z_after_101", {31'b0, z_ov}, 1);
    step(1'b0, 1'b0, "basic4");

    // Overlap stream 1,0,1,0,1 from idle
    step(1'b0, 1'b1, "ovl_rst");
    step(1'b1, 1'b0, "ovl1");
    step(1'b0, 1'b0, "ovl2");
    step(1'b1, 1'b0, "ovl3");
    step(1'b0, 1'b0, "ovl4");
    step(1'b1, 1'b0, "ovl5");
    check("ovl5_z_ov_high", {31'b0, z_ov}, 1);
    check("ovl5_z_no_low", {31'b0, z_no}, 0);

    // Non-matching stream 1,1,0,0,1,1
    step(1'b0, 1'b1, "nm_rst");
    step(1'b1, 1'b0, "nm1");
    step(1'b1, 1'b0, "nm2");
    step(1'b0, 1'b0, "nm3");
    step(1'b0, 1'b0, "nm4");
    step(1'b1, 1'b0, "nm5");
    step(1'b1, 1'b0, "nm6");

    // Reset mid-sequence overrides x=1 from S2
    step(1'b1, 1'b0, "mid1");
    step(1'b0, 1'b0, "mid2");
    step(1'b1, 1'b1, "mid_rst");
    step(1'b1, 1'b0, "mid3");
    step(1'b0, 1'b0, "mid4");
    step(1'b1, 1'b0, "mid5");

    // Randomised stream with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(1)), ($urandom_range(39) == 0) ? 1'b1 : 1'b0, "rnd");
    end

`ifdef MOORE_SEQ_DETECT_CNT_EN
    // Three overlapping matches, then reset, then drive the counter to saturation
    step(1'b0, 1'b1, "cnt_rst");
    step(1'b1, 1'b0, "cnt3");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, "cnt3");
      step(1'b1, 1'b0, "cnt3");
    end
    check("cnt_three", {24'b0, cnt_ov}, 3);
    step(1'b0, 1'b1, "cnt_clr");
    step(1'b1, 1'b0, "sat");
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b0, "sat");
      step(1'b1, 1'b0, "sat");
    end
    check("cnt_saturated", {24'b0, cnt_ov}, 255);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
